// File: rtl/bus_rx_endpoint_if.sv
// Signal bundle between the bus receive endpoint and its arbiter/consumer side.
// push is a strobe with no backpressure; a read transfers on every edge where rd_valid && rd_en.
interface bus_rx_endpoint_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  localparam int cw = $clog2(depth) + 1;

  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rd_en;
  logic               clr_stats;
  logic               rd_valid;
  logic [pckg_sz-1:0] rd_data;
  logic [cw-1:0]      count;
  logic               full;
  logic [15:0]        overflow_cnt;
  logic [15:0]        misroute_cnt;
  logic               underflow;

  modport master (
    output push, D_push, rd_en, clr_stats,
    input  rd_valid, rd_data, count, full, overflow_cnt, misroute_cnt, underflow
  );

  modport slave (
    input  push, D_push, rd_en, clr_stats,
    output rd_valid, rd_data, count, full, overflow_cnt, misroute_cnt, underflow
  );
endinterface

// File: rtl/bus_rx_endpoint.sv
// Receive endpoint: filters arbiter packets by destination ID into a FWFT FIFO
// and keeps saturating drop statistics.
module bus_rx_endpoint #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input logic              clk,
  input logic              reset,
  bus_rx_endpoint_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [pckg_sz-1:0] mem [depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic [cw-1:0]      count_q;
  logic [15:0]        overflow_q;
  logic [15:0]        misroute_q;
  logic               underflow_q;

  logic [7:0] dst;
  logic       match;
  logic       not_empty;
  logic       is_full;
  logic       pop_ok;
  logic       accept;
  logic       ovf_hit;
  logic       mis_hit;

  always_comb begin
    dst       = bus.D_push[pckg_sz-1 -: 8];
    match     = (dst == id) || (dst == broadcast);
    not_empty = (count_q != '0);
    is_full   = (count_q == cw'(depth));
    pop_ok    = bus.rd_en && not_empty;
    // A pop on the same edge frees a slot, so a full FIFO can still take the packet.
    accept    = bus.push && match && (!is_full || pop_ok);
    mis_hit   = bus.push && !match;
    ovf_hit   = bus.push && match && is_full && !pop_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !accept) count_q <= count_q - 1'b1;
    end
  end

  // Storage carries no reset; stale entries are never visible because count gates rd_valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.D_push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= '0;
      misroute_q  <= '0;
      underflow_q <= 1'b0;
    end else if (bus.clr_stats) begin
      overflow_q  <= '0;
      misroute_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_hit && overflow_q != 16'hFFFF) overflow_q <= overflow_q + 16'd1;
      if (mis_hit && misroute_q != 16'hFFFF) misroute_q <= misroute_q + 16'd1;
      if (bus.rd_en && !not_empty) underflow_q <= 1'b1;
    end
  end

  always_comb begin
    bus.rd_valid     = not_empty;
    bus.rd_data      = not_empty ? mem[rd_ptr] : '0;
    bus.count        = count_q;
    bus.full         = is_full;
    bus.overflow_cnt = overflow_q;
    bus.misroute_cnt = misroute_q;
    bus.underflow    = underflow_q;
  end
endmodule

// File: doc/bus_rx_endpoint.md
Name: bus_rx_endpoint

Overview:
- Receive-side endpoint for one device on the bus generator/arbiter fabric.
- Consumes the arbiter's push/D_push output for one device slot and filters packets by destination ID.
- Buffers accepted packets in a first-word-fall-through FIFO for a local consumer.
- Keeps saturating drop/misroute statistics.
- Mirror of the transmit-side driver FIFO that feeds pndng/pop/D_pop.

Parameters:
- pckg_sz, 16, packet width in bits; destination ID is D_push[pckg_sz-1:pckg_sz-8]; must be >= 9.
- depth, 8, FIFO entries; power of two, >= 2.
- id, 0, 8-bit device ID of this endpoint.
- broadcast, 8'hFF, destination ID accepted by every endpoint.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  arbiter strobe: D_push is valid this cycle.
- D_push  in  pckg_sz  packet from arbiter, stored whole (header included).
- rd_en  in  1  consumer pop request.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_data  out  pckg_sz  head-of-FIFO packet; 0 when rd_valid=0.
- count  out  $clog2(depth)+1  number of stored packets.
- full  out  1  count==depth.
- overflow_cnt  out  16  packets dropped because the FIFO was full; saturating.
- misroute_cnt  out  16  packets dropped because dst is neither id nor broadcast; saturating.
- underflow  out  1  sticky: rd_en seen while rd_valid=0.
- clr_stats  in  1  synchronous pulse; clears overflow_cnt, misroute_cnt, underflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - Write and read pointers, count, overflow_cnt, misroute_cnt and underflow go to 0 immediately.
  - Outputs follow: rd_valid=0, rd_data=0, full=0.
  - FIFO memory contents are don't-care.
  - Release is sampled at the next clk edge.
- Address match: match = (dst==id) || (dst==broadcast).
- Pop: pop_ok = rd_en && rd_valid, evaluated on pre-edge state.
- Accept: accept = push && match && (!full || pop_ok).
  - On accept, mem[wr_ptr] <= D_push and wr_ptr increments, wrapping modulo depth.
- Pop action: pop_ok advances rd_ptr, wrapping modulo depth.
- count update per edge:
  - +1 on accept without pop_ok.
  - -1 on pop_ok without accept.
  - Unchanged when both or neither occur.
- Latency: a packet accepted at edge N appears on rd_data/rd_valid after edge N (first-word-fall-through).
  - rd_data = mem[rd_ptr] when rd_valid, else 0.
  - rd_valid = (count!=0).
- Empty FIFO with push and rd_en in the same cycle:
  - The pop is not valid (rd_valid=0), so underflow is set.
  - The packet is stored; count=1 after the edge.
- Full FIFO:
  - push + match + rd_en in the same cycle: packet accepted, count stays at depth, ordering preserved.
  - push + match without rd_en: packet dropped, overflow_cnt +1, memory and pointers untouched.
- push && !match: packet dropped, misroute_cnt +1, regardless of full. Misroute takes precedence, so overflow_cnt is not incremented.
- Counters saturate at 16'hFFFF; no wrap.
- clr_stats:
  - When high at an edge, the stats are cleared.
  - Clear wins over increments occurring in that same cycle.
  - Does not affect FIFO contents.
- rd_en with rd_valid=0: underflow <= 1; pointers and count unchanged.
- Reset mid-operation: all stored packets are discarded; no partial state survives.
- No combinational path from push/D_push to rd_valid/rd_data. rd_en affects outputs only after the edge.

Test Plan:
- Reset: hold reset=0 with push=1, D_push=16'h00AB → rd_valid=0, count=0, both counters 0, underflow=0; after release, outputs stay 0 until the first push.
- id=0, depth=4, push 16'h00AB one cycle → next cycle rd_valid=1, rd_data=16'h00AB, count=1; pulse rd_en → rd_valid=0, rd_data=0, count=0.
- Addressing: push 16'hFF11 then 16'h0522 → rd_data=16'hFF11, count=1, misroute_cnt=1; 16'h0522 is never visible.
- Overflow, depth=4:
  - Push 16'h0001..16'h0004 → full=1.
  - Push 16'h0005 without rd_en → overflow_cnt=1, count=4.
  - Push 16'h0006 with rd_en=1 → accepted.
  - Drain order: 0002, 0003, 0004, 0006.
- Underflow/stats:
  - rd_en on empty → underflow=1, count=0.
  - Simultaneous push 16'h0033 + rd_en on empty → count=1, rd_data=16'h0033.
  - clr_stats pulse → underflow=0 and counters 0, FIFO still holds 16'h0033.
- Async reset mid-stream: with count=3, drop reset low between edges → count=0, rd_valid=0 before the next clk edge; no stale data after release.
